// File: rtl/psw_pkg.sv
// psw_pkg: shared definitions for the program-status unit.
//   FLG_Z/FLG_C/FLG_N/FLG_V : bit positions of the flags in a 4-bit flag word
//   cond_e                  : 4-bit branch-condition encoding
//   cond_eval()             : pure condition evaluator, also used by the
//                             microsequencer's static predictor
package psw_pkg;

    localparam int unsigned FLG_Z = 0;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_N = 2;
    localparam int unsigned FLG_V = 3;

    typedef enum logic [3:0] {
        EQ = 4'd0,  NE = 4'd1,
        HS = 4'd2,  LO = 4'd3,
        HI = 4'd4,  LS = 4'd5,
        MI = 4'd6,  PL = 4'd7,
        VS = 4'd8,  VC = 4'd9,
        GE = 4'd10, LT = 4'd11,
        GT = 4'd12, LE = 4'd13,
        AL = 4'd14, NV = 4'd15
    } cond_e;

    // C is a borrow flag: C=1 means unsigned "lower".
    function automatic logic cond_eval(input logic [3:0] f, input cond_e c);
        logic z;
        logic cy;
        logic n;
        logic v;
        logic r;
        z  = f[FLG_Z];
        cy = f[FLG_C];
        n  = f[FLG_N];
        v  = f[FLG_V];
        r  = 1'b0;
        case (c)
            EQ: r = z;
            NE: r = ~z;
            HS: r = ~cy;
            LO: r = cy;
            HI: r = ~z & ~cy;
            LS: r = z | cy;
            MI: r = n;
            PL: r = ~n;
            VS: r = v;
            VC: r = ~v;
            GE: r = (n == v);
            LT: r = (n != v);
            GT: r = ~z & (n == v);
            LE: r = z | (n != v);
            AL: r = 1'b1;
            NV: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/psw_cond_unit_if.sv
// psw_cond_unit_if: bus between the ALU/sequencer side (master) and the
// program-status unit (slave).
//   master drives: flag_we, flag_in, br_valid, br_cond, push, pop, err_clr
//   slave drives : flags, jmp, jmp_valid, stk_cnt, stk_err
interface psw_cond_unit_if #(
    parameter int unsigned STACK_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

    logic [3:0]       flag_we;
    logic [3:0]       flag_in;
    logic             br_valid;
    logic [3:0]       br_cond;
    logic             push;
    logic             pop;
    logic             err_clr;
    logic [3:0]       flags;
    logic             jmp;
    logic             jmp_valid;
    logic [CNT_W-1:0] stk_cnt;
    logic             stk_err;

    modport master (
        output flag_we, flag_in, br_valid, br_cond, push, pop, err_clr,
        input  flags, jmp, jmp_valid, stk_cnt, stk_err
    );

    modport slave (
        input  flag_we, flag_in, br_valid, br_cond, push, pop, err_clr,
        output flags, jmp, jmp_valid, stk_cnt, stk_err
    );

endinterface

// File: rtl/psw_flag_stack.sv
// psw_flag_stack: STACK_DEPTH x 4-bit LIFO for flag save/restore.
//   push/pop : already qualified by the parent (never both, never illegal)
//   din      : flag word to store on push
//   top      : most recently stored entry (undefined when empty)
//   count    : entries occupied; full/empty derived from it
module psw_flag_stack #(
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push,
    input  logic                               pop,
    input  logic [3:0]                         din,
    output logic [3:0]                         top,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   count,
    output logic                               full,
    output logic                               empty
);
    localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [3:0]       mem_q [STACK_DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    always_comb begin
        full    = (count_q == CNT_W'(STACK_DEPTH));
        empty   = (count_q == '0);
        wr_idx  = IDX_W'(count_q);
        rd_idx  = IDX_W'(count_q - CNT_W'(1));
        count_d = count_q;
        if (push && !full) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !empty) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage is never read while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_idx] <= din;
        end
    end

    assign top   = mem_q[rd_idx];
    assign count = count_q;

endmodule

// File: rtl/psw_cond_unit.sv
// psw_cond_unit: architectural Z/C/N/V flags with per-flag write enables,
// registered branch-condition evaluation, and a flag save/restore stack.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of psw_cond_unit_if (flag writes, branch requests,
//                push/pop/err_clr in; flags, jmp/jmp_valid, stk_cnt, stk_err out)
// BYPASS=1 lets a branch see flag writes made in the same cycle.
module psw_cond_unit
    import psw_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 4,
    parameter bit          BYPASS      = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    psw_cond_unit_if.slave       bus
);
    localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

    logic [3:0]       flags_q;
    logic [3:0]       flags_d;
    logic             jmp_q;
    logic             jmp_d;
    logic             jmp_valid_q;
    logic             jmp_valid_d;
    logic             stk_err_q;
    logic             stk_err_d;

    logic [3:0]       wr_flags;
    logic [3:0]       eff_flags;
    logic             push_ok;
    logic             pop_ok;
    logic             stk_fault;
    logic [3:0]       stk_top;
    logic [CNT_W-1:0] stk_count;
    logic             stk_full;
    logic             stk_empty;

    always_comb begin
        wr_flags  = (bus.flag_in & bus.flag_we) | (flags_q & ~bus.flag_we);
        // Forwarding only ever covers flag_we data, never a popped value.
        eff_flags = BYPASS ? wr_flags : flags_q;

        push_ok   = bus.push & ~bus.pop & ~stk_full;
        pop_ok    = bus.pop  & ~bus.push & ~stk_empty;
        stk_fault = (bus.push & bus.pop)
                  | (bus.push & ~bus.pop & stk_full)
                  | (bus.pop  & ~bus.push & stk_empty);

        flags_d     = pop_ok ? stk_top : wr_flags;
        jmp_valid_d = bus.br_valid;
        jmp_d       = bus.br_valid & cond_eval(eff_flags, cond_e'(bus.br_cond));
        // A new fault wins over a same-cycle clear.
        stk_err_d   = stk_fault | (stk_err_q & ~bus.err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q     <= '0;
            jmp_q       <= 1'b0;
            jmp_valid_q <= 1'b0;
            stk_err_q   <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            jmp_q       <= jmp_d;
            jmp_valid_q <= jmp_valid_d;
            stk_err_q   <= stk_err_d;
        end
    end

    // Push saves the flags as registered, before any same-cycle write.
    psw_flag_stack #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok),
        .pop   (pop_ok),
        .din   (flags_q),
        .top   (stk_top),
        .count (stk_count),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign bus.flags     = flags_q;
    assign bus.jmp       = jmp_q;
    assign bus.jmp_valid = jmp_valid_q;
    assign bus.stk_cnt   = stk_count;
    assign bus.stk_err   = stk_err_q;

endmodule

// File: tb/tb_psw_cond_unit.sv
module tb_psw_cond_unit;
    localparam int unsigned DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] we;
    logic [3:0] fin;
    logic       bv;
    logic [3:0] bc;
    logic       push;
    logic       pop;
    logic       clr;

    int errors = 0;
    int checks = 0;

    psw_cond_unit_if #(.STACK_DEPTH(DEPTH)) bus0 ();
    psw_cond_unit_if #(.STACK_DEPTH(DEPTH)) bus1 ();

    assign bus0.flag_we  = we;   assign bus1.flag_we  = we;
    assign bus0.flag_in  = fin;  assign bus1.flag_in  = fin;
    assign bus0.br_valid = bv;   assign bus1.br_valid = bv;
    assign bus0.br_cond  = bc;   assign bus1.br_cond  = bc;
    assign bus0.push     = push; assign bus1.push     = push;
    assign bus0.pop      = pop;  assign bus1.pop      = pop;
    assign bus0.err_clr  = clr;  assign bus1.err_clr  = clr;

    psw_cond_unit #(.STACK_DEPTH(DEPTH), .BYPASS(1'b0)) dut0 (
        .clk (clk), .rst_n (rst_n), .bus (bus0)
    );
    psw_cond_unit #(.STACK_DEPTH(DEPTH), .BYPASS(1'b1)) dut1 (
        .clk (clk), .rst_n (rst_n), .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: flags bits {V,N,C,Z}, stack as a queue.
    logic [3:0] m_flags;
    logic [3:0] m_stack [$];
    bit         m_err;

    logic [7:0] exp_state [$];   // {flags, cnt[2:0], err}
    logic [1:0] exp_j0 [$];      // {valid, jmp} for BYPASS=0
    logic [1:0] exp_j1 [$];      // {valid, jmp} for BYPASS=1

    function automatic bit ref_cond(input logic [3:0] fl, input int cc);
        bit z, c, n, v, less, r;
        z = fl[0]; c = fl[1]; n = fl[2]; v = fl[3];
        less = (n != v);             // signed less-than
        case (cc)
            0:  r = z;
            1:  r = !z;
            2:  r = !c;              // unsigned higher-or-same: no borrow
            3:  r = c;
            4:  r = !(z || c);
            5:  r = z || c;
            6:  r = n;
            7:  r = !n;
            8:  r = v;
            9:  r = !v;
            10: r = !less;
            11: r = less;
            12: r = !(z || less);
            13: r = z || less;
            14: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    task automatic step();
        logic [3:0] merged;
        logic [3:0] popped;
        bit         fault;
        bit         did_pop;
        bit         j0;
        bit         j1;
        if (!rst_n) begin
            m_flags = '0;
            m_stack.delete();
            m_err = 1'b0;
            exp_state.push_back(8'h00);
            exp_j0.push_back(2'b00);
            exp_j1.push_back(2'b00);
        end else begin
            merged = (m_flags & ~we) | (fin & we);
            j0 = bv && ref_cond(m_flags, int'(bc));
            j1 = bv && ref_cond(merged, int'(bc));
            fault = 1'b0;
            did_pop = 1'b0;
            popped = '0;
            if (push && pop) begin
                fault = 1'b1;
            end else if (push) begin
                if (m_stack.size() == DEPTH) fault = 1'b1;
                else m_stack.push_back(m_flags);
            end else if (pop) begin
                if (m_stack.size() == 0) fault = 1'b1;
                else begin
                    popped = m_stack.pop_back();
                    did_pop = 1'b1;
                end
            end
            m_flags = did_pop ? popped : merged;
            m_err = fault || (m_err && !clr);
            exp_state.push_back({m_flags, 3'(m_stack.size()), m_err});
            exp_j0.push_back({bv, j0});
            exp_j1.push_back({bv, j1});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] w, input logic [3:0] f, input logic v,
                         input logic [3:0] c, input logic ps, input logic pp,
                         input logic cl);
        we = w; fin = f; bv = v; bc = c; push = ps; pop = pp; clr = cl;
        step();
    endtask

    task automatic chk(input string name, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    // Monitor: compares whatever the DUTs present against queued expectations.
    always @(negedge clk) begin
        logic [7:0] s;
        logic [1:0] j;
        if (exp_state.size() > 0) begin
            s = exp_state.pop_front();
            chk("flags",   0, int'(bus0.flags),   int'(s[7:4]));
            chk("stk_cnt", 0, int'(bus0.stk_cnt), int'(s[3:1]));
            chk("stk_err", 0, int'(bus0.stk_err), int'(s[0]));
            chk("flags",   1, int'(bus1.flags),   int'(s[7:4]));
            chk("stk_cnt", 1, int'(bus1.stk_cnt), int'(s[3:1]));
            chk("stk_err", 1, int'(bus1.stk_err), int'(s[0]));
        end
        if (exp_j0.size() > 0) begin
            j = exp_j0.pop_front();
            chk("jmp_valid", 0, int'(bus0.jmp_valid), int'(j[1]));
            chk("jmp",       0, int'(bus0.jmp),       int'(j[0]));
        end
        if (exp_j1.size() > 0) begin
            j = exp_j1.pop_front();
            chk("jmp_valid", 1, int'(bus1.jmp_valid), int'(j[1]));
            chk("jmp",       1, int'(bus1.jmp),       int'(j[0]));
        end
    end

    initial begin
        rst_n = 1'b0;
        we = '0; fin = '0; bv = 1'b0; bc = '0; push = 1'b0; pop = 1'b0; clr = 1'b0;
        m_flags = '0; m_err = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Basic conditions on reset flags.
        drive(4'h0, 4'h0, 1'b1, 4'd14, 1'b0, 1'b0, 1'b0);   // AL
        drive(4'h0, 4'h0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0);   // NV
        drive(4'h0, 4'h0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0);   // EQ, Z=0
        drive(4'h0, 4'h0, 1'b0, 4'd14, 1'b0, 1'b0, 1'b0);   // idle

        // Same-cycle Z write with EQ branch, then repeat.
        drive(4'b0001, 4'b0001, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        drive(4'h0,    4'h0,    1'b1, 4'd0, 1'b0, 1'b0, 1'b0);

        // N=1, V=0, Z=0: signed conditions.
        drive(4'hF, 4'b0100, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 10; k <= 13; k++) drive(4'h0, 4'h0, 1'b1, 4'(k), 1'b0, 1'b0, 1'b0);
        // C=1, Z=0: unsigned conditions.
        drive(4'hF, 4'b0010, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 2; k <= 5; k++) drive(4'h0, 4'h0, 1'b1, 4'(k), 1'b0, 1'b0, 1'b0);

        // Fill the stack past full with distinct flag values.
        for (int k = 0; k < 5; k++) drive(4'hF, 4'(k + 3), 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) drive(4'h0, 4'h0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        drive(4'h0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);    // err_clr

        // Illegal push+pop alongside a full flag write.
        drive(4'hF, 4'hF, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);    // one entry = 4'h?
        drive(4'hF, 4'b1010, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        // Clear while a new fault occurs: error must stay set.
        drive(4'h0, 4'h0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        drive(4'h0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        // Pop wins over a same-cycle flag write.
        drive(4'hF, 4'h5, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle: outputs must clear before the next edge.
        drive(4'hF, 4'h6, 1'b1, 4'd14, 1'b1, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        void'(exp_state.pop_back());
        void'(exp_j0.pop_back());
        void'(exp_j1.pop_back());
        exp_state.push_back(8'h00);
        exp_j0.push_back(2'b00);
        exp_j1.push_back(2'b00);
        m_flags = '0; m_stack.delete(); m_err = 1'b0;
        @(negedge clk);
        step();
        rst_n = 1'b1;
        drive(4'h0, 4'h0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);    // EQ sees flags=0
        drive(4'h0, 4'h0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);    // NE

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 9) == 0));
        end

        drive(4'h0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psw_cond_unit.md
# psw_cond_unit

Parametrised program-status unit for the micro-programmed CPU. It holds four architectural flags (Z, C, N, V) with per-flag write enables, and evaluates a full 16-entry branch-condition set into a registered jump decision. It also provides a flag save/restore stack of configurable depth for interrupt entry and return. It sits between the ALU flag outputs and the microsequencer's jump input, and supersedes the two-flag status block.

## Interface
Parameters:
- STACK_DEPTH, 4: number of flag-stack entries (≥1).
- BYPASS, 0: 1 = conditions see flags written in the same cycle (forwarded); 0 = conditions see the registered flags only.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- flag_we  in  4  per-flag write enable; bit0 Z, bit1 C, bit2 N, bit3 V.
- flag_in  in  4  new flag values, same bit order.
- br_valid  in  1  branch-evaluation request this cycle.
- br_cond  in  4  condition code, encodings listed under Operation.
- push  in  1  save the current flags to the stack.
- pop  in  1  restore the flags from the stack.
- err_clr  in  1  clear the sticky stack error.
- flags  out  4  registered flag state.
- jmp  out  1  registered branch-taken decision.
- jmp_valid  out  1  one-cycle pulse marking jmp as meaningful.
- stk_cnt  out  $clog2(STACK_DEPTH+1)  number of stack entries occupied.
- stk_err  out  1  sticky error: overflow, underflow or illegal push+pop.

## Operation
- C is a borrow flag: C=1 means unsigned "lower".
- Condition encodings:
  - 0 EQ: Z. 1 NE: ~Z.
  - 2 HS: ~C. 3 LO: C.
  - 4 HI: ~Z&~C. 5 LS: Z|C.
  - 6 MI: N. 7 PL: ~N.
  - 8 VS: V. 9 VC: ~V.
  - 10 GE: N==V. 11 LT: N!=V.
  - 12 GT: ~Z&(N==V). 13 LE: Z|(N!=V).
  - 14 AL: 1. 15 NV: 0.
- Effective flags:
  - BYPASS=1: for each bit, flag_in where flag_we is set, otherwise the register value.
  - BYPASS=0: the register value.
- Flag update priority within a cycle: legal pop > flag_we > hold.
  - A pop restores all four flags from the top entry and ignores flag_we.
  - BYPASS forwarding never forwards a popped value.
- Push stores the register flags as they were before any same-cycle write. stk_cnt increments.
- Push when full: no store, count unchanged, stk_err←1.
- Pop when empty: flags unchanged, flag_we still applies, stk_err←1.
- Push and pop in the same cycle: both ignored, flag_we still applies, stk_err←1.
- stk_err stays set until err_clr, or until reset. If err_clr and a new error occur in the same cycle, stk_err=1.
- Stack is LIFO. Entry contents are undefined after reset and are never read when empty.

## Timing
- Reset values: flags=0, jmp=0, jmp_valid=0, stk_cnt=0, stk_err=0. Stack entries need not be reset.
- br_valid in cycle T: jmp and jmp_valid are driven at the edge ending T. jmp_valid lasts one cycle.
- br_valid=0: jmp=0 and jmp_valid=0 on the next cycle.
- Back-to-back br_valid is supported at one decision per cycle.
- Flag write at T is visible on `flags` from T+1.
- Evaluation of that write:
  - BYPASS=1: a branch evaluated at T sees the write.
  - BYPASS=0: a branch at T+1 is the first to see it.
- Push or pop at T: stk_cnt updates at T+1. Popped flags are visible at T+1.
- Reset asserted mid-operation clears all state immediately. The first branch after deassertion sees flags=0.

## Structure
- Shared package psw_pkg holds:
  - flag bit-index constants FLG_Z, FLG_C, FLG_N, FLG_V;
  - the 4-bit cond_e enum (EQ…NV);
  - a pure function cond_eval(flags, cond) that is reused by the microsequencer's static predictor.
- Sub-module psw_flag_stack (STACK_DEPTH × 4-bit LIFO):
  - inputs: push, pop, and the data to store;
  - outputs: top, count, full, empty;
  - error generation stays in the parent.

## Test plan
- Reset, then br_valid with cond=AL → jmp=1, jmp_valid=1 one cycle later. cond=NV → jmp=0. cond=EQ → jmp=0, since Z=0.
- flag_we=4'b0001, flag_in=4'b0001 at T with EQ branch at T: BYPASS=1 → jmp=1. BYPASS=0 → jmp=0, and a repeat at T+1 → jmp=1.
- flags N=1, V=0, Z=0: LT→1, GE→0, GT→0, LE→1. flags C=1, Z=0: LO→1, HS→0, HI→0, LS→1.
- DEPTH=4: push 5 times with distinct flags → stk_cnt=4, stk_err=1. Then 4 pops return the flags in reverse order. A 5th pop → flags unchanged, stk_err stays 1. err_clr → stk_err=0.
- push=1 and pop=1 together, with flag_we=4'b1111 and flag_in=4'b1010 → stk_cnt unchanged, flags=4'b1010, stk_err=1.
- Pop with flag_we=4'b1111 in the same cycle → flags equal the stacked value. Assert rst_n low mid-sequence → all outputs 0 asynchronously.
